// File: rtl/pec_streamer_sink.sv
// Result write-back streamer: takes one NFT-feature result vector per element
// and emits it as packed 32-bit words (two 16-bit features per word) with
// consecutive byte addresses, one layer of el_sz*el_sz elements per start.
module pec_streamer_sink #(
    parameter int unsigned NFT = 16,
    parameter int unsigned RW  = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [7:0]        ft_sz_i,
    input  logic [7:0]        el_sz_i,
    input  logic [31:0]       out_addr_i,
    input  logic              res_valid_i,
    output logic              res_ready_o,
    input  logic [NFT*RW-1:0] res_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       out_data_o,
    output logic [31:0]       out_addr_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_RES = 2'd1;
    localparam logic [1:0] ST_SEND     = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [7:0]        r_ft_sz;
    logic [7:0]        r_el_sz;
    logic [31:0]       r_base;
    logic [15:0]       r_el_cnt;
    logic [7:0]        r_word_cnt;
    logic [NFT*RW-1:0] r_res;

    logic [7:0]        w_words_per_el;
    logic [15:0]       w_total_el;
    logic              w_last_word;
    logic              w_last_el;
    logic [8:0]        w_lo_idx;
    logic [8:0]        w_hi_idx;
    logic [RW-1:0]     w_lo_f;
    logic [RW-1:0]     w_hi_f;
    logic [31:0]       w_word_idx;

    // Widened to 9 bits so ft_sz=255 yields 128 rather than wrapping.
    assign w_words_per_el = 8'((9'(r_ft_sz) + 9'd1) >> 1);
    assign w_total_el     = 16'(r_el_sz) * 16'(r_el_sz);
    assign w_last_word    = (r_word_cnt == (w_words_per_el - 8'd1));
    assign w_last_el      = (r_el_cnt == (w_total_el - 16'd1));
    assign w_lo_idx       = {r_word_cnt, 1'b0};
    assign w_hi_idx       = {r_word_cnt, 1'b1};
    assign w_word_idx     = 32'(r_el_cnt) * 32'(w_words_per_el) + 32'(r_word_cnt);

    // Feature select for the current word; features past ft_sz or NFT read as 0.
    always_comb begin
        w_lo_f = '0;
        w_hi_f = '0;
        for (int f = 0; f < int'(NFT); f++) begin
            if (f == int'(w_lo_idx)) begin
                w_lo_f = r_res[f*RW +: RW];
            end
            if ((f == int'(w_hi_idx)) && (f < int'(r_ft_sz))) begin
                w_hi_f = r_res[f*RW +: RW];
            end
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (start_i) w_state_nxt = ST_WAIT_RES;
            ST_WAIT_RES: if (res_valid_i) w_state_nxt = ST_SEND;
            ST_SEND: begin
                if (out_ready_i && w_last_word) begin
                    w_state_nxt = w_last_el ? ST_DONE : ST_WAIT_RES;
                end
            end
            ST_DONE:     w_state_nxt = ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // State, latched layer parameters, counters and the result register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_ft_sz    <= '0;
            r_el_sz    <= '0;
            r_base     <= '0;
            r_el_cnt   <= '0;
            r_word_cnt <= '0;
            r_res      <= '0;
        end else if (clear_i) begin
            r_state    <= ST_IDLE;
            r_el_cnt   <= '0;
            r_word_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        // Zero sizes are stored as 1 so all downstream math sees >= 1.
                        r_ft_sz    <= (ft_sz_i == 8'd0) ? 8'd1 : ft_sz_i;
                        r_el_sz    <= (el_sz_i == 8'd0) ? 8'd1 : el_sz_i;
                        r_base     <= out_addr_i;
                        r_el_cnt   <= '0;
                        r_word_cnt <= '0;
                    end
                end
                ST_WAIT_RES: begin
                    if (res_valid_i) begin
                        r_res      <= res_data_i;
                        r_word_cnt <= '0;
                    end
                end
                ST_SEND: begin
                    if (out_ready_i) begin
                        if (!w_last_word) begin
                            r_word_cnt <= r_word_cnt + 8'd1;
                        end else if (!w_last_el) begin
                            r_el_cnt <= r_el_cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign res_ready_o = (r_state == ST_WAIT_RES);
    assign out_valid_o = (r_state == ST_SEND);
    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = (r_state == ST_DONE);
    assign out_data_o  = out_valid_o ? {16'(w_hi_f), 16'(w_lo_f)} : 32'd0;
    assign out_addr_o  = out_valid_o ? (r_base + (w_word_idx << 2)) : 32'd0;

endmodule
